// File: rtl/sincos_cordic_seq.sv
// Sequential CORDIC sine/cosine unit.
// Takes a signed integer angle in degrees over a valid/ready handshake, reduces it
// to [0,359], folds it into [-90,90], runs ITER micro-rotations and returns
// cos/sin in Q2.(OUT_W-2).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for an angle, in_ready=1
// REDUCE | restoring subtraction of 360<<k, one step per cycle
// FOLD   | map [0,359] onto [-90,90] plus a sign flip, load x/y/z
// ROTATE | one CORDIC micro-rotation per cycle
// DONE   | register rounded/saturated result, hold until out_ready
module sincos_cordic_seq #(
    parameter int ANG_W = 16,
    parameter int OUT_W = 16,
    parameter int ITER  = 14,
    parameter int ZF    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ANG_W-1:0] theta,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] cos_out,
    output logic signed [OUT_W-1:0] sin_out
);

    localparam int RS = ANG_W - 9;
    localparam int KW = (RS > 1) ? $clog2(RS) : 1;
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int AW = ANG_W + 1;
    // x/y carry two guard bits plus one bit of headroom above the output range
    localparam int XW = OUT_W + 3;
    // z covers +/-256 degrees with ZF fractional bits
    localparam int ZW = ZF + 9;

    localparam logic [AW-1:0] C360 = AW'(360);
    localparam int KX = $rtoi(0.6072529 * (2.0 ** (OUT_W - 2)) + 0.5);
    localparam logic signed [XW-1:0] XINIT = XW'(KX * 4);
    localparam logic signed [XW:0] MAXV = (XW + 1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [XW:0] MINV = (XW + 1)'(-(2 ** (OUT_W - 1)));

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        FOLD,
        ROTATE,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]          a;
    logic                   s;
    logic [KW-1:0]          k;
    logic [IW-1:0]          i;
    logic signed [XW-1:0]   x, y;
    logic signed [ZW-1:0]   z;
    logic                   neg;

    logic signed [AW-1:0]   theta_ext;
    logic [AW-1:0]          a_abs;
    logic [AW-1:0]          red_step;
    logic [8:0]             r;
    logic signed [9:0]      zdeg;
    logic                   fold_neg;
    logic signed [ZW-1:0]   z_load;
    logic signed [XW-1:0]   xs, ys;
    logic signed [ZW-1:0]   atan_rom [ITER];

    // atan(2^-n) in degrees; beyond n=15 the small-angle form is exact to well below ZF
    function automatic real atan_deg(input int n);
        case (n)
            0:       atan_deg = 45.0;
            1:       atan_deg = 26.56505117707799;
            2:       atan_deg = 14.036243467926479;
            3:       atan_deg = 7.125016348901798;
            4:       atan_deg = 3.5763343749973515;
            5:       atan_deg = 1.7899106082460694;
            6:       atan_deg = 0.8951737102110744;
            7:       atan_deg = 0.4476141708605531;
            8:       atan_deg = 0.22381050036853808;
            9:       atan_deg = 0.1119056770662069;
            10:      atan_deg = 0.05595289189380367;
            11:      atan_deg = 0.02797645261700368;
            12:      atan_deg = 0.013988227142265015;
            13:      atan_deg = 0.006994113675352919;
            14:      atan_deg = 0.003497056950704462;
            15:      atan_deg = 0.0017485284886807184;
            default: atan_deg = 57.29577951308232 / (2.0 ** n);
        endcase
    endfunction

    // drop the two guard bits with round-half-up, then clip to OUT_W
    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [XW-1:0] v);
        logic signed [XW:0] t;
        logic signed [OUT_W-1:0] res;
        t = signed'({v[XW-1], v}) + signed'((XW + 1)'(2));
        t = t >>> 2;
        if (t > MAXV)
            res = MAXV[OUT_W-1:0];
        else if (t < MINV)
            res = MINV[OUT_W-1:0];
        else
            res = t[OUT_W-1:0];
        return res;
    endfunction

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        localparam int VAL = $rtoi(atan_deg(g) * (2.0 ** ZF) + 0.5);
        assign atan_rom[g] = ZW'(VAL);
    end

    assign theta_ext = {theta[ANG_W-1], theta};
    assign a_abs     = theta[ANG_W-1] ? -theta_ext : theta_ext;
    assign red_step  = C360 << k;
    assign xs        = x >>> i;
    assign ys        = y >>> i;
    assign z_load    = {{(ZW - 10){zdeg[9]}}, zdeg} <<< ZF;

    // fold the reduced angle into [-90,90] and note whether both outputs flip sign
    always_comb begin
        r = a[8:0];
        if (s && (a != '0))
            r = 9'd360 - a[8:0];
        zdeg     = '0;
        fold_neg = 1'b0;
        if (r <= 9'd90) begin
            zdeg = signed'({1'b0, r});
        end else if (r <= 9'd270) begin
            zdeg     = signed'({1'b0, r}) - 10'sd180;
            fold_neg = 1'b1;
        end else begin
            zdeg = signed'({1'b0, r}) - 10'sd360;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic and handshake output
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = REDUCE;
            end
            REDUCE: begin
                if (k == '0)
                    state_nxt = FOLD;
            end
            FOLD:   state_nxt = ROTATE;
            ROTATE: begin
                if (i == IW'(ITER - 1))
                    state_nxt = DONE;
            end
            DONE: begin
                if (out_valid && out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // datapath: capture, reduce, fold, rotate and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= '0;
            s         <= 1'b0;
            k         <= '0;
            i         <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            neg       <= 1'b0;
            out_valid <= 1'b0;
            cos_out   <= '0;
            sin_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a <= a_abs;
                        s <= theta[ANG_W-1];
                        k <= KW'(RS - 1);
                    end
                end
                REDUCE: begin
                    if (a >= red_step)
                        a <= a - red_step;
                    k <= k - 1'b1;
                end
                FOLD: begin
                    z   <= z_load;
                    neg <= fold_neg;
                    x   <= XINIT;
                    y   <= '0;
                    i   <= '0;
                end
                ROTATE: begin
                    i <= i + 1'b1;
                    if (!z[ZW-1]) begin
                        x <= x - ys;
                        y <= y + xs;
                        z <= z - atan_rom[i];
                    end else begin
                        x <= x + ys;
                        y <= y - xs;
                        z <= z + atan_rom[i];
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        cos_out   <= round_sat(neg ? -x : x);
                        sin_out   <= round_sat(neg ? -y : y);
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sincos_cordic_seq.sv
// Bench for sincos_cordic_seq: default instance plus a narrow (12/12/10) instance,
// checked against real-valued sin/cos of the angle reduced modulo 360.
`timescale 1ns/1ps
module tb_sincos_cordic_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic in_valid, in_ready, out_valid, out_ready;
    logic signed [15:0] theta, cos_out, sin_out;

    logic in_valid2, in_ready2, out_valid2, out_ready2;
    logic signed [11:0] theta2, cos2, sin2;

    int tests = 0;
    int fails = 0;

    sincos_cordic_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .theta     (theta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out)
    );

    sincos_cordic_seq #(.ANG_W(12), .OUT_W(12), .ITER(10), .ZF(16)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .theta     (theta2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .cos_out   (cos2),
        .sin_out   (sin2)
    );

    function automatic int ref_val(input int th, input int ow, input bit want_sin);
        int m;
        real rad, v;
        m = th % 360;
        if (m < 0) m += 360;
        rad = real'(m) * 3.14159265358979323846 / 180.0;
        v = (want_sin ? $sin(rad) : $cos(rad)) * (2.0 ** (ow - 2));
        return $rtoi(v + ((v >= 0.0) ? 0.5 : -0.5));
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic signed [63:0] obs, input int exp);
        logic signed [63:0] diff;
        logic ok;
        tests++;
        diff = obs - 64'(exp);
        ok = (diff <= 4) && (diff >= -4);
        assert (ok === 1'b1) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (+/-4)", tag, obs, exp);
        end
    endtask

    // drive one angle into dut, wait for out_valid, check latency and busy in_ready
    task automatic start1(input int th, output int lat);
        bit ir_hi;
        @(negedge clk);
        chk($sformatf("in_ready_idle th=%0d", th), in_ready, 1);
        in_valid = 1'b1;
        theta    = 16'(th);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        theta    = 16'(th + 77);
        lat   = 0;
        ir_hi = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ir_hi = 1'b1;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk($sformatf("in_ready_busy th=%0d", th), ir_hi, 0);
        chk($sformatf("latency th=%0d", th), lat, 23);
    endtask

    task automatic do_one(input int th);
        int lat;
        start1(th, lat);
        chk_tol($sformatf("cos th=%0d", th), cos_out, ref_val(th, 16, 1'b0));
        chk_tol($sformatf("sin th=%0d", th), sin_out, ref_val(th, 16, 1'b1));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("out_valid_clr th=%0d", th), out_valid, 0);
        chk($sformatf("in_ready_back th=%0d", th), in_ready, 1);
    endtask

    task automatic do_two(input int th);
        int lat;
        @(negedge clk);
        in_valid2 = 1'b1;
        theta2    = 12'(th);
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v2_latency th=%0d", th), lat, 15);
        chk_tol($sformatf("v2_cos th=%0d", th), cos2, ref_val(th, 12, 1'b0));
        chk_tol($sformatf("v2_sin th=%0d", th), sin2, ref_val(th, 12, 1'b1));
        out_ready2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v2_in_ready_back th=%0d", th), in_ready2, 1);
    endtask

    initial begin
        int dirs[$];
        int lat;
        int th;
        logic signed [15:0] hc, hs;
        bit seen;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        theta      = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        theta2     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cos", cos_out, 0);
        chk("rst_sin", sin_out, 0);
        chk("rst_v2_out_valid", out_valid2, 0);
        rst = 1'b0;

        // directed angles, including out-of-range and extreme negatives
        dirs = '{0, 30, 90, 150, 180, 200, 270, 300, 360, 390, -30, -32768, 32767, -720, 719};
        foreach (dirs[n]) do_one(dirs[n]);

        // random angles over the full 16-bit range
        for (int n = 0; n < 16; n++) begin
            th = int'($urandom_range(65535)) - 32768;
            do_one(th);
        end

        // backpressure: hold the result for 10 cycles while in_valid is pulsed
        out_ready = 1'b0;
        start1(45, lat);
        hc = cos_out;
        hs = sin_out;
        chk_tol("bp_cos", hc, ref_val(45, 16, 1'b0));
        chk_tol("bp_sin", hs, ref_val(45, 16, 1'b1));
        for (int n = 0; n < 10; n++) begin
            in_valid = 1'b1;
            theta    = 16'(123);
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_cos_stable", cos_out, hc);
            chk("bp_sin_stable", sin_out, hs);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        chk("bp_cos_kept", cos_out, hc);
        do_one(10);

        // reset while rotating: no stale result may appear afterwards
        in_valid = 1'b1;
        theta    = 16'(60);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_cos", cos_out, 0);
        chk("midrst_sin", sin_out, 0);
        chk("midrst_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_stale", seen, 0);
        do_one(-45);

        // narrow instance
        do_two(-90);
        do_two(0);
        for (int n = 0; n < 4; n++) begin
            th = int'($urandom_range(4095)) - 2048;
            do_two(th);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
